// File: rtl/id_ex_latch_if.sv
// Decode-to-execute bus for the ID/EX latch: decoded operands/control in,
// registered copies plus the load-use stall and bubble counter out.
interface id_ex_latch_if;
    logic        ihit;
    logic        dmem_busy;
    logic        flush;
    logic [31:0] imemload_if_id_output;
    logic [31:0] pcplus4_if_id_output;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm_ext;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        halt;
    logic [3:0]  aluop;
    logic [1:0]  regdst;

    logic [31:0] imemload_id_ex_output;
    logic [31:0] pcplus4_id_ex_output;
    logic [31:0] rdat1_id_ex_output;
    logic [31:0] rdat2_id_ex_output;
    logic [31:0] imm_id_ex_output;
    logic        regwrite_id_ex_output;
    logic        memread_id_ex_output;
    logic        memwrite_id_ex_output;
    logic        memtoreg_id_ex_output;
    logic        alusrc_id_ex_output;
    logic        halt_id_ex_output;
    logic [3:0]  aluop_id_ex_output;
    logic [4:0]  dest_id_ex_output;
    logic        stall;
    logic [15:0] bubble_count;

    modport master (
        output ihit, dmem_busy, flush, imemload_if_id_output, pcplus4_if_id_output,
               rdat1, rdat2, imm_ext, regwrite, memread, memwrite, memtoreg,
               alusrc, halt, aluop, regdst,
        input  imemload_id_ex_output, pcplus4_id_ex_output, rdat1_id_ex_output,
               rdat2_id_ex_output, imm_id_ex_output, regwrite_id_ex_output,
               memread_id_ex_output, memwrite_id_ex_output, memtoreg_id_ex_output,
               alusrc_id_ex_output, halt_id_ex_output, aluop_id_ex_output,
               dest_id_ex_output, stall, bubble_count
    );

    modport slave (
        input  ihit, dmem_busy, flush, imemload_if_id_output, pcplus4_if_id_output,
               rdat1, rdat2, imm_ext, regwrite, memread, memwrite, memtoreg,
               alusrc, halt, aluop, regdst,
        output imemload_id_ex_output, pcplus4_id_ex_output, rdat1_id_ex_output,
               rdat2_id_ex_output, imm_id_ex_output, regwrite_id_ex_output,
               memread_id_ex_output, memwrite_id_ex_output, memtoreg_id_ex_output,
               alusrc_id_ex_output, halt_id_ex_output, aluop_id_ex_output,
               dest_id_ex_output, stall, bubble_count
    );
endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection and bubble counter.
// Latency: 1 cycle decode->execute; stall is combinational from ID/EX state.
// Backpressure: holds everything while ~ihit or dmem_busy; flush/hazard load a bubble.
module id_ex_latch (
    input  logic         CLK,
    input  logic         nRST,
    id_ex_latch_if.slave bus
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        halt;
        logic [3:0]  aluop;
        logic [4:0]  dest;
    } idex_t;

    idex_t       idex_q;
    idex_t       idex_d;
    logic [15:0] bubble_cnt_q;
    logic        advance;
    logic        hazard;
    logic [4:0]  dest_nxt;

    assign advance = bus.ihit & ~bus.dmem_busy;

    always_comb begin
        dest_nxt = bus.imemload_if_id_output[20:16];
        case (bus.regdst)
            2'b01:   dest_nxt = bus.imemload_if_id_output[15:11];
            2'b10:   dest_nxt = 5'd31;
            default: dest_nxt = bus.imemload_if_id_output[20:16];
        endcase
    end

    // A load to $0 never produces a value, so it can never create a hazard.
    assign hazard = idex_q.memread & idex_q.regwrite & (idex_q.dest != 5'd0) &
                    ((idex_q.dest == bus.imemload_if_id_output[25:21]) |
                     (idex_q.dest == bus.imemload_if_id_output[20:16]));

    assign bus.stall = hazard & ~bus.flush;

    always_comb begin
        idex_d          = '0;
        idex_d.instr    = bus.imemload_if_id_output;
        idex_d.pcplus4  = bus.pcplus4_if_id_output;
        idex_d.rdat1    = bus.rdat1;
        idex_d.rdat2    = bus.rdat2;
        idex_d.imm      = bus.imm_ext;
        idex_d.regwrite = bus.regwrite;
        idex_d.memread  = bus.memread;
        idex_d.memwrite = bus.memwrite;
        idex_d.memtoreg = bus.memtoreg;
        idex_d.alusrc   = bus.alusrc;
        idex_d.halt     = bus.halt;
        idex_d.aluop    = bus.aluop;
        idex_d.dest     = dest_nxt;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            idex_q       <= '0;
            bubble_cnt_q <= '0;
        end else if (advance) begin
            if (bus.flush) begin
                idex_q <= '0;
            end else if (hazard) begin
                idex_q <= '0;
                if (bubble_cnt_q != 16'hFFFF)
                    bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end else begin
                idex_q <= idex_d;
            end
        end
    end

    assign bus.imemload_id_ex_output = idex_q.instr;
    assign bus.pcplus4_id_ex_output  = idex_q.pcplus4;
    assign bus.rdat1_id_ex_output    = idex_q.rdat1;
    assign bus.rdat2_id_ex_output    = idex_q.rdat2;
    assign bus.imm_id_ex_output      = idex_q.imm;
    assign bus.regwrite_id_ex_output = idex_q.regwrite;
    assign bus.memread_id_ex_output  = idex_q.memread;
    assign bus.memwrite_id_ex_output = idex_q.memwrite;
    assign bus.memtoreg_id_ex_output = idex_q.memtoreg;
    assign bus.alusrc_id_ex_output   = idex_q.alusrc;
    assign bus.halt_id_ex_output     = idex_q.halt;
    assign bus.aluop_id_ex_output    = idex_q.aluop;
    assign bus.dest_id_ex_output     = idex_q.dest;
    assign bus.bubble_count          = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: capture, load-use bubbles, flush, hold,
// $0 handling, counter saturation and asynchronous reset.
module tb_id_ex_latch;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_pass;

    localparam logic [31:0] LW5  = 32'h8C250000; // lw   $5,0($1)
    localparam logic [31:0] LW0  = 32'h8C200000; // lw   $0,0($1)
    localparam logic [31:0] ADDU = 32'h00221821; // addu $3,$1,$2
    localparam logic [31:0] USRS = 32'h00A23020; // add  $6,$5,$2
    localparam logic [31:0] USRT = 32'h00453020; // add  $6,$2,$5
    localparam logic [31:0] USE0 = 32'h00003020; // add  $6,$0,$0

    id_ex_latch_if bus ();

    id_ex_latch dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [1:0] rdst,
                         input logic rw, input logic mr);
        bus.imemload_if_id_output = instr;
        bus.regdst   = rdst;
        bus.regwrite = rw;
        bus.memread  = mr;
        bus.memtoreg = mr;
        bus.alusrc   = mr;
        bus.memwrite = 1'b0;
        bus.halt     = 1'b0;
        bus.aluop    = 4'h1;
    endtask

    task automatic test_reset();
        bus.ihit = 1'b1;
        bus.dmem_busy = 1'b0;
        bus.flush = 1'b0;
        bus.pcplus4_if_id_output = $urandom;
        bus.rdat1 = $urandom;
        bus.rdat2 = $urandom;
        bus.imm_ext = $urandom;
        drive(LW5, 2'b00, 1'b1, 1'b1);
        tick();
        drive(USRS, 2'b01, 1'b1, 1'b0);
        #1;
        chk("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("rst_instr", bus.imemload_id_ex_output, 32'h0);
        chk("rst_pcplus4", bus.pcplus4_id_ex_output, 32'h0);
        chk("rst_rdat1", bus.rdat1_id_ex_output, 32'h0);
        chk("rst_ctrl", {26'd0, bus.regwrite_id_ex_output, bus.memread_id_ex_output,
            bus.memwrite_id_ex_output, bus.memtoreg_id_ex_output,
            bus.alusrc_id_ex_output, bus.halt_id_ex_output}, 32'h0);
        chk("rst_dest", {27'd0, bus.dest_id_ex_output}, 32'h0);
        chk("rst_bubble_count", {16'd0, bus.bubble_count}, 32'h0);
        chk("rst_stall", {31'd0, bus.stall}, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_capture();
        drive(ADDU, 2'b01, 1'b1, 1'b0);
        bus.pcplus4_if_id_output = 32'h0000_0104;
        bus.rdat1   = 32'h0000_0011;
        bus.rdat2   = 32'h0000_0022;
        bus.imm_ext = 32'h0000_1821;
        bus.aluop   = 4'h2;
        bus.halt    = 1'b1;
        tick();
        chk("cap_instr", bus.imemload_id_ex_output, ADDU);
        chk("cap_dest_rd", {27'd0, bus.dest_id_ex_output}, 32'd3);
        chk("cap_regwrite", {31'd0, bus.regwrite_id_ex_output}, 32'd1);
        chk("cap_pcplus4", bus.pcplus4_id_ex_output, 32'h0000_0104);
        chk("cap_rdat2", bus.rdat2_id_ex_output, 32'h0000_0022);
        chk("cap_imm", bus.imm_id_ex_output, 32'h0000_1821);
        chk("cap_aluop", {28'd0, bus.aluop_id_ex_output}, 32'h2);
        chk("cap_halt", {31'd0, bus.halt_id_ex_output}, 32'd1);
        drive(ADDU, 2'b10, 1'b1, 1'b0);
        tick();
        chk("cap_dest_31", {27'd0, bus.dest_id_ex_output}, 32'd31);
        drive(ADDU, 2'b11, 1'b1, 1'b0);
        tick();
        chk("cap_dest_11_rt", {27'd0, bus.dest_id_ex_output}, 32'd2);
    endtask

    task automatic test_load_use();
        drive(LW5, 2'b00, 1'b1, 1'b1);
        tick();
        chk("lu_lw_dest", {27'd0, bus.dest_id_ex_output}, 32'd5);
        chk("lu_lw_memread", {31'd0, bus.memread_id_ex_output}, 32'd1);
        drive(USRS, 2'b01, 1'b1, 1'b0);
        #1;
        chk("lu_stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("lu_bubble_instr", bus.imemload_id_ex_output, 32'h0);
        chk("lu_bubble_ctrl", {29'd0, bus.regwrite_id_ex_output, bus.memread_id_ex_output,
            bus.memtoreg_id_ex_output}, 32'h0);
        chk("lu_bubble_dest", {27'd0, bus.dest_id_ex_output}, 32'd0);
        chk("lu_bubble_count", {16'd0, bus.bubble_count}, 32'd1);
        chk("lu_stall_clear", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("lu_add_captured", bus.imemload_id_ex_output, USRS);
        chk("lu_add_dest", {27'd0, bus.dest_id_ex_output}, 32'd6);
    endtask

    task automatic test_flush();
        drive(LW5, 2'b00, 1'b1, 1'b1);
        tick();
        drive(USRS, 2'b01, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("fl_bubble_instr", bus.imemload_id_ex_output, 32'h0);
        chk("fl_bubble_count", {16'd0, bus.bubble_count}, 32'd1);
    endtask

    task automatic test_hold();
        drive(LW5, 2'b00, 1'b1, 1'b1);
        tick();
        drive(USRT, 2'b01, 1'b1, 1'b0);
        bus.dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rdat1 = 32'hA000_0000 + i;
            bus.pcplus4_if_id_output = 32'h0000_0200 + 4 * i;
            #1;
            chk("hold_stall", {31'd0, bus.stall}, 32'd1);
            tick();
            chk("hold_instr", bus.imemload_id_ex_output, LW5);
            chk("hold_count", {16'd0, bus.bubble_count}, 32'd1);
        end
        bus.dmem_busy = 1'b0;
        tick();
        chk("hold_release_bubble", bus.imemload_id_ex_output, 32'h0);
        chk("hold_release_count", {16'd0, bus.bubble_count}, 32'd2);
        bus.ihit = 1'b0;
        drive(ADDU, 2'b01, 1'b1, 1'b0);
        tick();
        chk("nohit_hold", bus.imemload_id_ex_output, 32'h0);
        bus.ihit = 1'b1;
        tick();
        chk("hit_capture", bus.imemload_id_ex_output, ADDU);
    endtask

    task automatic test_zero_dest();
        drive(LW0, 2'b00, 1'b1, 1'b1);
        tick();
        drive(USE0, 2'b01, 1'b1, 1'b0);
        #1;
        chk("zero_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("zero_captured", bus.imemload_id_ex_output, USE0);
        chk("zero_count", {16'd0, bus.bubble_count}, 32'd2);
    endtask

    task automatic test_saturate();
        force dut.bubble_cnt_q = 16'hFFFD;
        #1;
        release dut.bubble_cnt_q;
        for (int i = 0; i < 3; i++) begin
            drive(LW5, 2'b00, 1'b1, 1'b1);
            tick();
            drive(USRS, 2'b01, 1'b1, 1'b0);
            tick();
            chk("sat_count", {16'd0, bus.bubble_count},
                (i == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nrst = 1'b0;
        bus.ihit = 1'b0;
        bus.dmem_busy = 1'b0;
        bus.flush = 1'b0;
        bus.pcplus4_if_id_output = '0;
        bus.rdat1 = '0;
        bus.rdat2 = '0;
        bus.imm_ext = '0;
        drive(32'h0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        test_reset();
        test_capture();
        test_load_use();
        test_flush();
        test_hold();
        test_zero_dest();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

ID/EX pipeline register with integrated load-use hazard detection for the five-stage MIPS pipeline. It captures decoded operands and control from the decode stage and presents them to execute and to the forwarding unit: instruction word, regwrite, destination register. It inserts bubbles on flush or load-use hazards and asserts a stall back to fetch/decode. It also keeps a saturating count of inserted load-use bubbles for performance debug.

## Interface
Parameters:
- None. Widths are fixed by `cpu_types_pkg`: 32-bit words, 5-bit register indices.

Ports:
- CLK  input  1  pipeline clock; all state updates on rising edge.
- nRST  input  1  asynchronous, active-low reset.
- ihit  input  1  instruction cache hit; the pipeline may advance.
- dmem_busy  input  1  MEM stage waiting on dcache; the pipeline must hold.
- flush  input  1  branch/jump taken in execute; squash the decode instruction.
- imemload_if_id_output  input  32  instruction word from IF/ID.
- pcplus4_if_id_output  input  32  PC+4 from IF/ID.
- rdat1, rdat2  input  32 each  register file read data (rs, rt).
- imm_ext  input  32  sign/zero-extended immediate.
- regwrite, memread, memwrite, memtoreg, alusrc, halt  input  1 each  decoded control.
- aluop  input  4  decoded ALU operation.
- regdst  input  2  destination select: 00 rt, 01 rd, 10 $31, 11 treated as rt.
- imemload_id_ex_output, pcplus4_id_ex_output, rdat1_id_ex_output, rdat2_id_ex_output, imm_id_ex_output  output  32 each  registered copies.
- regwrite_id_ex_output, memread_id_ex_output, memwrite_id_ex_output, memtoreg_id_ex_output, alusrc_id_ex_output, halt_id_ex_output  output  1 each  registered control.
- aluop_id_ex_output  output  4  registered ALU op.
- dest_id_ex_output  output  5  registered destination register index.
- stall  output  1  combinational load-use stall to the PC and IF/ID (hold).
- bubble_count  output  16  saturating count of load-use bubbles.

## Operation
- advance = ihit & ~dmem_busy.
- dest (next) = regdst 01 → imemload[15:11]; 10 → 5'd31; else imemload[20:16].
- hazard = memread_id_ex_output & regwrite_id_ex_output & (dest_id_ex_output != 0) & (dest_id_ex_output == imemload_if_id_output[25:21] | dest_id_ex_output == imemload_if_id_output[20:16]).
- stall = hazard & ~flush. Flush overrides: the squashed instruction needs no stall.
- Register update priority, each rising edge:
  1. ~advance: hold all registers.
  2. flush: load bubble.
  3. hazard: load bubble. If bubble_count != 16'hFFFF, increment it.
  4. Otherwise capture all inputs; dest from the rule above.
- Bubble: all control outputs 0, instruction 32'h0 (sll $0 NOP), dest 0, data fields 0, halt 0.
- A bubble clears memread, so hazard deasserts the next cycle; a load-use costs exactly one bubble.
- halt passes through like any control bit; this block has no sticky halt.

## Timing
- Reset (nRST low, asynchronous): every registered output is 0, bubble_count is 0, and stall reads 0 because memread_id_ex_output is 0. Reset mid-stall clears state immediately, with no clock needed.
- Capture latency: 1 cycle. Decode values on edge N appear at the outputs after edge N.
- stall is combinational from registered state plus imemload_if_id_output, with no extra cycle. Fetch and IF/ID must hold on the same edge that ID/EX loads the bubble.
- Hazard while ~advance: stall stays asserted, registers hold, and bubble_count does not increment until an advancing edge.
- Flush and hazard together: one bubble, bubble_count unchanged, stall 0.
- bubble_count saturates at 16'hFFFF and never wraps.
- dest == 0 never causes a stall.

## Test plan
- Reset: drive random inputs, pulse nRST low mid-cycle → all outputs 0 asynchronously, bubble_count 0, stall 0.
- Plain capture: ihit=1, addu $3,$1,$2 (32'h00221821), regdst=01, regwrite=1 → next edge imemload_id_ex_output=32'h00221821, dest_id_ex_output=3, regwrite_id_ex_output=1.
- Load-use: lw $5,0($1) captured (memread=1, regwrite=1, regdst=00), then decode holds add $6,$5,$2 → stall=1 that cycle. Next edge: bubble (all control 0, instr 0), bubble_count=1, stall=0. Following edge: add is captured.
- Flush priority: lw $5 in ID/EX, decode uses $5, flush=1 → stall=0, bubble loaded, bubble_count stays 0.
- Hold: dmem_busy=1 for 3 cycles with changing decode inputs → outputs unchanged. With a pending hazard, stall stays 1 for all 3 cycles and bubble_count does not change until the first edge with dmem_busy=0.
- $0 and saturation: lw $0 then use of $0 → no stall. Preload 16'hFFFE bubbles via repeated hazards → the counter reaches 16'hFFFF and stays there on the next hazard.
